// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU
// Holds the pipeline via combinational busy; abort cancels an in-flight divide.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic [REG_AW-1:0] reg_waddr_i,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] reg_waddr_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                is_rem_q, q_neg, r_neg;
  logic [REG_AW-1:0]   waddr_q;
  logic [DATA_W-1:0]   dvd, dsr, rem;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic [DATA_W-1:0]   rem_nx, dvd_nx, q_fin, r_fin;
  logic                a_neg, b_neg, last, accept;

  assign a_neg  = ~op[0] & dividend[DATA_W-1];
  assign b_neg  = ~op[0] & divisor[DATA_W-1];
  assign last   = (cnt == CNT_W'(DATA_W - 1));
  assign accept = start & ~abort;

  // One restoring step; the borrow out of the (DATA_W+1)-bit subtract is the compare.
  always_comb begin
    rem_sh   = {rem, dvd[DATA_W-1]};
    rem_diff = rem_sh - {1'b0, dsr};
    dvd_nx   = {dvd[DATA_W-2:0], ~rem_diff[DATA_W]};
    rem_nx   = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
    q_fin    = q_neg ? -dvd_nx : dvd_nx;
    r_fin    = r_neg ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        busy = accept;
        if (accept) state_n = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (abort)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      ready       <= 1'b0;
      result      <= '0;
      reg_waddr_o <= '0;
      is_rem_q    <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      waddr_q     <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem_q <= op[1];
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            waddr_q  <= reg_waddr_i;
            dvd      <= a_neg ? -dividend : dividend;
            dsr      <= b_neg ? -divisor : divisor;
            rem      <= '0;
            cnt      <= '0;
            if (divisor == '0) begin
              result      <= op[1] ? dividend : '1;
              ready       <= 1'b1;
              reg_waddr_o <= reg_waddr_i;
            end
          end
        end
        CALC: begin
          if (!abort) begin
            dvd <= dvd_nx;
            rem <= rem_nx;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              result      <= is_rem_q ? r_fin : q_fin;
              ready       <= 1'b1;
              reg_waddr_o <= waddr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        busy, ready;
  logic [31:0] result;
  logic [4:0]  reg_waddr_o;

  div_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .dividend(dividend), .divisor(divisor), .reg_waddr_i(reg_waddr_i),
    .busy(busy), .ready(ready), .result(result), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && !o[0]) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'd0:    return 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (ready) begin
      n_ready++;
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(ready), 32'd0);
      end else begin
        e_m = sb.pop_front();
        check("result", result, e_m.res);
        check("waddr", 32'(reg_waddr_o), 32'(e_m.wa));
        check("latency", 32'(cyc), 32'(e_m.due));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic [31:0] exp,
                       input bit dz, input bit follow, input bit push);
    int lat;
    int t;
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b; reg_waddr_i = wa;
    lat = dz ? 1 : 33;
    t = cyc;
    if (push) sb.push_back('{res: exp, wa: wa, due: t + lat});
    if (follow) begin
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        check("busy", 32'(busy), 32'(i < lat));
        if (i == 0) begin
          @(posedge clk); #1;
          start = 1'b0; dividend = $urandom; divisor = $urandom; reg_waddr_i = 5'($urandom);
        end
      end
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          pulses;

    repeat (2) @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    issue(2'd1, 32'd100, 32'd7, 5'd3, 32'd14, 0, 1, 1);
    issue(2'd3, 32'd100, 32'd7, 5'd4, 32'd2, 0, 1, 1);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 0, 1, 1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0, 1, 1);
    issue(2'd0, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 0, 1, 1);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 0, 1, 1);
    issue(2'd0, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 1, 1);
    issue(2'd3, 32'd5, 32'd0, 5'd10, 32'd5, 1, 1, 1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1, 1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 1, 1);
    wait_idle();

    for (int k = 0; k < 8; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      issue(ro, ra, rb, 5'(k + 20), model(ro, ra, rb), 0, 1, 1);
    end
    wait_idle();

    // second start mid-operation must not disturb the first
    issue(2'd1, 32'd100, 32'd7, 5'd13, 32'd14, 0, 0, 1);
    repeat (4) @(posedge clk); #1;
    start = 1'b1; op = 2'd3; dividend = 32'd55; divisor = 32'd4; reg_waddr_i = 5'd20;
    @(negedge clk);
    check("busy_ignored", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // abort at T+10, restart at T+12
    issue(2'd1, 32'd1000, 32'd3, 5'd14, 32'd0, 0, 0, 0);
    repeat (9) @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("busy_at_abort", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("busy_after_abort", 32'(busy), 32'd0);
    check("result_after_abort", result, 32'd14);
    issue(2'd1, 32'd9, 32'd3, 5'd15, 32'd3, 0, 1, 1);
    wait_idle();

    // reset mid-operation at T+20
    issue(2'd1, 32'd100, 32'd7, 5'd16, 32'd0, 0, 0, 0);
    repeat (19) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_waddr", 32'(reg_waddr_o), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    pulses = n_ready;
    repeat (40) @(negedge clk);
    check("midrst_no_pulse", 32'(n_ready), 32'(pulses));
    check("midrst_result_hold", result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
